// File: rtl/yacht_score_unit.sv
// yacht_score_unit: latches five dice, builds a face histogram one die per
// cycle, then scores the 12 Yacht categories one per cycle into a register file.
`timescale 1ns/1ps
module yacht_score_unit #(
    parameter int unsigned SMALL_STRAIGHT_PTS = 15,
    parameter int unsigned LARGE_STRAIGHT_PTS = 30,
    parameter int unsigned YACHT_PTS          = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [2:0] dice1,
    input  logic [2:0] dice2,
    input  logic [2:0] dice3,
    input  logic [2:0] dice4,
    input  logic [2:0] dice5,
    input  logic [3:0] cat_sel,
    output logic [5:0] score_out,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic       err,
    output logic [3:0] best_cat,
    output logic [5:0] best_score
);

    localparam int unsigned NUM_DICE  = 5;
    localparam int unsigned NUM_FACES = 6;
    localparam int unsigned NUM_CATS  = 12;
    localparam int unsigned FACE_W    = 3;
    localparam int unsigned SUM_W     = 5;
    localparam int unsigned SCORE_W   = 6;
    localparam int unsigned CAT_W     = 4;
    localparam int unsigned STEP_W    = 4;

    localparam logic [STEP_W-1:0] LAST_DIE = STEP_W'(NUM_DICE - 1);
    localparam logic [STEP_W-1:0] LAST_CAT = STEP_W'(NUM_CATS - 1);

    typedef enum logic [1:0] {IDLE, COUNT, EVAL, DONE} state_t;

    state_t                                 state, state_next;
    logic                                   start_accept_c;
    logic [STEP_W-1:0]                      step_q;
    logic [NUM_DICE-1:0][FACE_W-1:0]        dice_q;
    logic [NUM_FACES-1:0][FACE_W-1:0]       hist_q;
    logic [SUM_W-1:0]                       sum_q;
    logic [SCORE_W-1:0]                     scores_q [NUM_CATS];
    logic                                   busy_q, done_q, valid_q, err_q;
    logic [CAT_W-1:0]                       best_cat_q;
    logic [SCORE_W-1:0]                     best_score_q;

    logic [FACE_W-1:0]                      cur_face_c;
    logic                                   cur_legal_c;
    logic                                   illegal_in_c;
    logic [NUM_FACES-1:0]                   present_c;
    logic                                   has_two_c, has_three_c, has_four_c, has_five_c;
    logic [SCORE_W-1:0]                     score_c;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic; start is only honoured when not busy
    always_comb begin
        state_next     = state;
        start_accept_c = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = COUNT;
                    start_accept_c = 1'b1;
                end
            end
            COUNT:   if (step_q == LAST_DIE) state_next = EVAL;
            EVAL:    if (step_q == LAST_CAT) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Input legality check and current-die selection
    always_comb begin
        illegal_in_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            illegal_in_c = illegal_in_c;
        end
        illegal_in_c = (dice1 == 3'd0) || (dice1 == 3'd7) ||
                       (dice2 == 3'd0) || (dice2 == 3'd7) ||
                       (dice3 == 3'd0) || (dice3 == 3'd7) ||
                       (dice4 == 3'd0) || (dice4 == 3'd7) ||
                       (dice5 == 3'd0) || (dice5 == 3'd7);
        cur_face_c  = dice_q[step_q[2:0]];
        cur_legal_c = (cur_face_c != 3'd0) && (cur_face_c != 3'd7);
    end

    // Histogram features and score of the category indexed by step_q
    always_comb begin
        present_c   = '0;
        has_two_c   = 1'b0;
        has_three_c = 1'b0;
        has_four_c  = 1'b0;
        has_five_c  = 1'b0;
        score_c     = '0;
        for (int f = 0; f < NUM_FACES; f++) begin
            present_c[f] = (hist_q[f] != 3'd0);
            has_two_c    = has_two_c   | (hist_q[f] == 3'd2);
            has_three_c  = has_three_c | (hist_q[f] == 3'd3);
            has_four_c   = has_four_c  | (hist_q[f] >= 3'd4);
            has_five_c   = has_five_c  | (hist_q[f] == 3'd5);
        end
        if (!err_q) begin
            case (step_q)
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5:
                    score_c = SCORE_W'(hist_q[step_q[2:0]]) * (SCORE_W'(step_q) + SCORE_W'(1));
                4'd6:  score_c = SCORE_W'(sum_q);
                4'd7:  score_c = has_four_c ? SCORE_W'(sum_q) : '0;
                4'd8:  score_c = (has_three_c && has_two_c) ? SCORE_W'(sum_q) : '0;
                4'd9:  score_c = ((&present_c[3:0]) || (&present_c[4:1]) || (&present_c[5:2]))
                                 ? SCORE_W'(SMALL_STRAIGHT_PTS) : '0;
                4'd10: score_c = ((&present_c[4:0]) || (&present_c[5:1]))
                                 ? SCORE_W'(LARGE_STRAIGHT_PTS) : '0;
                4'd11: score_c = has_five_c ? SCORE_W'(YACHT_PTS) : '0;
                default: score_c = '0;
            endcase
        end
    end

    // Datapath: latch, count, evaluate, track best and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_q       <= '0;
            dice_q       <= '0;
            hist_q       <= '0;
            sum_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
            best_cat_q   <= '0;
            best_score_q <= '0;
            for (int i = 0; i < NUM_CATS; i++) scores_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_accept_c) begin
                dice_q       <= {dice5, dice4, dice3, dice2, dice1};
                hist_q       <= '0;
                sum_q        <= '0;
                step_q       <= '0;
                best_cat_q   <= '0;
                best_score_q <= '0;
                valid_q      <= 1'b0;
                busy_q       <= 1'b1;
                err_q        <= illegal_in_c;
            end else if (state == COUNT) begin
                if (cur_legal_c) begin
                    hist_q[cur_face_c - 3'd1] <= hist_q[cur_face_c - 3'd1] + 3'd1;
                    sum_q                     <= sum_q + SUM_W'(cur_face_c);
                end
                step_q <= (step_q == LAST_DIE) ? '0 : step_q + STEP_W'(1);
            end else if (state == EVAL) begin
                scores_q[step_q] <= score_c;
                if (score_c > best_score_q) begin
                    best_score_q <= score_c;
                    best_cat_q   <= CAT_W'(step_q);
                end
                if (step_q == LAST_CAT) begin
                    step_q  <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    valid_q <= 1'b1;
                end else begin
                    step_q <= step_q + STEP_W'(1);
                end
            end
        end
    end

    // Random-access read port; out-of-range categories read as zero
    assign score_out  = (cat_sel < CAT_W'(NUM_CATS)) ? scores_q[cat_sel] : '0;
    assign busy       = busy_q;
    assign done       = done_q;
    assign valid      = valid_q;
    assign err        = err_q;
    assign best_cat   = best_cat_q;
    assign best_score = best_score_q;

endmodule

// File: tb/tb_yacht_score_unit.sv
// Self-checking bench for yacht_score_unit with a rule-level scoring model.
`timescale 1ns/1ps
module tb_yacht_score_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [2:0] dice1, dice2, dice3, dice4, dice5;
    logic [3:0] cat_sel;
    logic [5:0] score_out;
    logic       busy, done, valid, err;
    logic [3:0] best_cat;
    logic [5:0] best_score;

    int checks = 0;
    int errors = 0;

    yacht_score_unit dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .dice1(dice1), .dice2(dice2), .dice3(dice3), .dice4(dice4), .dice5(dice5),
        .cat_sel(cat_sel), .score_out(score_out), .busy(busy), .done(done),
        .valid(valid), .err(err), .best_cat(best_cat), .best_score(best_score)
    );

    always #5 clk = ~clk;

    // Reference scoring straight from the game rules
    function automatic void model(input int dv[5], output int es[12], output int bc,
                                  output int bs, output bit ee);
        int cnt[8];
        int sum;
        bit four, three, two, five, ss, ls;
        for (int f = 0; f < 8; f++) cnt[f] = 0;
        sum = 0; ee = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dv[i] == 0 || dv[i] == 7) ee = 1'b1;
            else begin cnt[dv[i]]++; sum += dv[i]; end
        end
        for (int c = 0; c < 12; c++) es[c] = 0;
        if (!ee) begin
            four = 0; three = 0; two = 0; five = 0;
            for (int f = 1; f <= 6; f++) begin
                es[f-1] = f * cnt[f];
                if (cnt[f] >= 4) four = 1;
                if (cnt[f] == 3) three = 1;
                if (cnt[f] == 2) two = 1;
                if (cnt[f] == 5) five = 1;
            end
            ss = 0; ls = 0;
            for (int lo = 1; lo <= 3; lo++)
                if (cnt[lo] > 0 && cnt[lo+1] > 0 && cnt[lo+2] > 0 && cnt[lo+3] > 0) ss = 1;
            for (int lo = 1; lo <= 2; lo++)
                if (cnt[lo] > 0 && cnt[lo+1] > 0 && cnt[lo+2] > 0 && cnt[lo+3] > 0 && cnt[lo+4] > 0) ls = 1;
            es[6]  = sum;
            es[7]  = four ? sum : 0;
            es[8]  = (three && two) ? sum : 0;
            es[9]  = ss ? 15 : 0;
            es[10] = ls ? 30 : 0;
            es[11] = five ? 50 : 0;
        end
        bc = 0; bs = 0;
        for (int c = 0; c < 12; c++) if (es[c] > bs) begin bs = es[c]; bc = c; end
    endfunction

    task automatic set_dice(input int dv[5]);
        dice1 = 3'(dv[0]); dice2 = 3'(dv[1]); dice3 = 3'(dv[2]);
        dice4 = 3'(dv[3]); dice5 = 3'(dv[4]);
    endtask

    task automatic scramble_dice();
        dice1 = 3'($urandom_range(0, 7)); dice2 = 3'($urandom_range(0, 7));
        dice3 = 3'($urandom_range(0, 7)); dice4 = 3'($urandom_range(0, 7));
        dice5 = 3'($urandom_range(0, 7));
    endtask

    // Presents dice with a one-cycle start pulse; returns at the negedge after the accepting edge
    task automatic start_roll(input int dv[5]);
        @(negedge clk);
        set_dice(dv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows a roll from the first busy cycle through done, then checks results
    task automatic finish_roll(input int dv[5], input bit repulse, input bit chain, input int dv_next[5]);
        int es[12];
        int bc, bs;
        bit ee, bad;
        model(dv, es, bc, bs, ee);
        bad = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad = 1'b1;
            if (repulse && k == 5) begin scramble_dice(); start = 1'b1; end
            else if (repulse && k == 6) start = 1'b0;
            else scramble_dice();
        end
        checks++;
        if (bad) begin errors++; $display("FAIL busy_window: busy/done wrong during 17-cycle busy window"); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b busy=%b valid=%b, required 1 0 1", done, busy, valid);
        end
        if (chain) begin
            set_dice(dv_next);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL back_to_back_accept: valid=%b busy=%b done=%b, required 0 1 0", valid, busy, done);
            end
            return;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL done_single: done=%b valid=%b, required 0 1", done, valid);
        end
        checks++;
        if (err !== ee) begin errors++; $display("FAIL err_flag: got %b, required %b", err, ee); end
        checks++;
        if (best_cat !== 4'(bc) || best_score !== 6'(bs)) begin
            errors++;
            $display("FAIL best: got cat %0d score %0d, required cat %0d score %0d", best_cat, best_score, bc, bs);
        end
        for (int c = 0; c < 12; c++) begin
            cat_sel = 4'(c);
            #1;
            checks++;
            if (score_out !== 6'(es[c])) begin
                errors++;
                $display("FAIL score_cat%0d: dice %0d%0d%0d%0d%0d got %0d, required %0d",
                         c, dv[0], dv[1], dv[2], dv[3], dv[4], score_out, es[c]);
            end
        end
    endtask

    task automatic roll(input int dv[5]);
        int none[5] = '{1, 1, 1, 1, 1};
        start_roll(dv);
        finish_roll(dv, 1'b0, 1'b0, none);
    endtask

    task automatic check_cat(input int c, input int expv, input string name);
        cat_sel = 4'(c);
        #1;
        checks++;
        if (score_out !== 6'(expv)) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, score_out, expv);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        bit bad;
        bad = (busy !== 1'b0) || (done !== 1'b0) || (valid !== 1'b0) || (err !== 1'b0) ||
              (best_cat !== 4'd0) || (best_score !== 6'd0);
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b valid=%b err=%b best_cat=%0d best_score=%0d, required all 0",
                     name, busy, done, valid, err, best_cat, best_score);
        end
        bad = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cat_sel = 4'(c);
            #0.1;
            if (score_out !== 6'd0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL %s_scores: register file not all 0", name); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; cat_sel = '0;
        set_dice('{1, 1, 1, 1, 1});
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        roll('{1, 1, 1, 1, 1});
        check_cat(11, 50, "yacht_ones");
        check_cat(8, 0, "fullhouse_not_yacht");
        roll('{2, 3, 4, 5, 6});
        check_cat(10, 30, "large_straight");
        check_cat(9, 15, "small_straight");
        roll('{3, 3, 3, 5, 5});
        check_cat(8, 19, "full_house");
        checks++;
        if (best_cat !== 4'd6) begin errors++; $display("FAIL tie_lower_index: best_cat %0d, required 6", best_cat); end
        roll('{0, 2, 2, 2, 2});
        check_cat(7, 0, "err_four_kind_zero");
        roll('{7, 1, 2, 3, 4});
    endtask

    task automatic test_cat_sel_oob();
        roll('{6, 6, 6, 6, 6});
        for (int c = 12; c < 16; c++) check_cat(c, 0, "cat_sel_oob");
    endtask

    task automatic test_start_ignored();
        int dv[5] = '{4, 4, 2, 2, 4};
        int none[5] = '{1, 1, 1, 1, 1};
        start_roll(dv);
        finish_roll(dv, 1'b1, 1'b0, none);
    endtask

    task automatic test_back_to_back();
        int a[5] = '{1, 2, 3, 4, 6};
        int b[5] = '{5, 5, 5, 5, 2};
        int none[5] = '{1, 1, 1, 1, 1};
        start_roll(a);
        finish_roll(a, 1'b0, 1'b1, b);
        finish_roll(b, 1'b0, 1'b0, none);
    endtask

    task automatic test_reset_mid();
        int dv[5] = '{0, 1, 2, 3, 4};
        start_roll(dv);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        @(negedge clk);
        reset_n = 1'b1;
        roll('{2, 2, 5, 5, 5});
    endtask

    task automatic test_random();
        int dv[5];
        int mode, a, b, base;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 3);
            a = $urandom_range(1, 6);
            b = $urandom_range(1, 6);
            base = $urandom_range(1, 2);
            for (int i = 0; i < 5; i++) begin
                case (mode)
                    0: dv[i] = $urandom_range(1, 6);
                    1: dv[i] = ($urandom_range(0, 1) != 0) ? a : b;
                    2: dv[i] = base + i;
                    default: dv[i] = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) != 0) ? 7 : 0)
                                                                 : $urandom_range(1, 6);
                endcase
            end
            if (mode == 2) dv[$urandom_range(0, 4)] = $urandom_range(1, 6);
            roll(dv);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_cat_sel_oob();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
